ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//  Initiator side of the shared 8-bit tri-state RAM bus used by the ram block.
//  Turns a host-side single-request handshake into the two-phase bus sequence:
//  address phase, then data phase. The data phase is driven by the master on a
//  write and by the RAM on a read. Sits between the cuca1 CPU core and the RAM.
//  It is the only block that drives enable/rw.
// PARAMETERS
//  WIDTH         8  bus, address and data width in bits
//  READ_LATENCY  1  cycles the bus is released after the address phase before
//                   read data is sampled; legal range 1..4
// PORTS
//  clock       in     1      system clock; all state changes on posedge
//  n_reset     in     1      asynchronous, active-low reset
//  req_valid   in     1      host request present
//  req_ready   out    1      master can accept a request this cycle
//  req_rw      in     1      1 = write, 0 = read
//  req_addr    in     WIDTH  target address
//  req_wdata   in     WIDTH  write data; ignored on reads
//  rsp_valid   out    1      one-cycle pulse: access complete
//  rsp_rdata   out    WIDTH  read data; valid only with rsp_valid after a read
//  enable      out    1      RAM select, to ram.enable
//  rw          out    1      RAM direction, to ram.rw (1 = write)
//  bus         inout  WIDTH  shared tri-state bus
// BEHAVIOUR
//  Reset (async, n_reset=0), applied immediately and also mid-transfer:
//  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, enable=0, rw=0.
//  - bus released to Z. Any in-flight access is dropped with no rsp_valid.
//  Handshake:
//  - Request accepted at the posedge where req_valid && req_ready.
//  - req_ready=1 only in IDLE.
//  - req_rw, req_addr and req_wdata are captured at acceptance; later host
//    changes are ignored.
//  FSM states and transitions (all registered outputs):
//  - IDLE  -> ADDR on accept.
//  - ADDR: enable=1, rw=req_rw, bus=addr (driven). Next: WDATA if write,
//    else RWAIT.
//  - WDATA: enable=1, rw=1, bus=wdata (driven). Next: IDLE with rsp_valid=1.
//  - RWAIT: enable=1, rw=0, bus released. A counter runs 0..READ_LATENCY-1.
//    At the posedge ending count READ_LATENCY-1: rsp_rdata<=bus, next IDLE
//    with rsp_valid=1.
//  - Any state other than IDLE: enable=1. IDLE: enable=0 and bus released.
//  Latency, accept edge to rsp_valid high: write = 2 cycles;
//  read = 1+READ_LATENCY cycles.
//  Back-to-back: the rsp_valid cycle is an IDLE cycle, so a new request can be
//  accepted in it. Full throughput is 1 access per 3 (write) or 2+READ_LATENCY
//  (read) cycles.
//  Bus ownership: the master drives bus only in ADDR and WDATA, never in RWAIT.
//  Write-to-read and read-to-write switches always pass through IDLE, so there
//  is never same-cycle contention.
//  rsp_rdata holds its last read value through writes and idle cycles.
//  Undefined (X/Z) bus values sampled in RWAIT propagate to rsp_rdata unchanged.
//  Simultaneous events: reset overrides everything. req_valid outside IDLE is
//  held off by req_ready=0 and is never dropped.
// STRUCTURE
//  - Package cuca1_bus_pkg: typedef enum logic[1:0] {IDLE, ADDR, WDATA, RWAIT}
//    bus_state_t; localparam BUS_WIDTH=8; localparam BUS_WRITE=1'b1,
//    BUS_READ=1'b0.
//  - Sub-module: the existing tri_buf (rw = drive enable, data, bus), one
//    instance of width WIDTH.
//  - Rest: one FSM always_ff, latency counter, request capture registers.
// TESTING (bench pairs ram_bus_master with the ram model on one shared bus)
//  1 Write 0x0F to addr 0x0A. Expected:
//    - ADDR cycle: bus=0x0A, en=1, rw=1.
//    - WDATA cycle: bus=0x0F.
//    - rsp_valid at accept+2; ram memory[10]==0x0F.
//  2 Read addr 0x0A after test 1. Expected:
//    - bus=Z during RWAIT.
//    - rsp_valid at accept+1+READ_LATENCY with rsp_rdata=0x0F.
//  3 Back-to-back: write 0x55->0x01, write 0xAA->0x02, read 0x01, read 0x02,
//    req_valid held high throughout. Expected:
//    - each accepted in its rsp_valid cycle; reads return 0x55, 0xAA;
//    - no X on bus from two drivers at any time.
//  4 Boundary addresses: write/read 0x00 and 0xFF with data 0xFF/0x00 -> values
//    match, no address wrap side effects.
//  5 Reset asserted mid-WDATA. Expected:
//    - same timestep: enable=0, bus=Z, req_ready=1;
//    - no rsp_valid afterwards.
//    After release, a read of 0x0A completes normally.
//  6 READ_LATENCY=3 build: read 0x0A -> bus released exactly 3 cycles,
//    rsp_valid at accept+4, data correct.

Source files
------------

// File: rtl/cuca1_bus_pkg.sv
// Shared types and constants for the cuca1 RAM bus.
package cuca1_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RWAIT = 2'd3
  } bus_state_t;

  localparam int   BUS_WIDTH = 8;
  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

endpackage

// File: rtl/tri_buf.sv
// Tri-state driver: puts data onto the shared bus while rw is high, else floats it.
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic             rw,
  input  logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = rw ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/ram_bus_master.sv
// Initiator for the shared tri-state RAM bus: turns one host request into an
// address phase followed by a data phase (master-driven on write, RAM-driven
// on read).
//
// Host handshake: a request transfers on the rising clock edge where
// req_valid && req_ready; req_ready is high only in IDLE, the request fields
// are captured on that edge, and a held req_valid is simply waited on.
// Completion is a single-cycle rsp_valid pulse, which is itself an IDLE cycle.
module ram_bus_master
  import cuca1_bus_pkg::*;
#(
  parameter int WIDTH        = BUS_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             enable,
  output logic             rw,
  inout  wire  [WIDTH-1:0] bus,
  output logic [1:0]       state
);

  // Last value of the read-wait counter; the bus is sampled on the edge ending it.
  localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

  bus_state_t       state_q;
  logic             drive;
  logic [WIDTH-1:0] drive_data;
  logic [WIDTH-1:0] wdata_q;
  logic [2:0]       wait_cnt;

  // Debug view of the FSM state for checkers.
  assign state = state_q;

  // Bus phase sequencer: all host and RAM-side outputs are registered here.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      enable     <= 1'b0;
      rw         <= BUS_READ;
      drive      <= 1'b0;
      drive_data <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q    <= ADDR;
            req_ready  <= 1'b0;
            enable     <= 1'b1;
            rw         <= req_rw;
            drive      <= 1'b1;
            drive_data <= req_addr;
            wdata_q    <= req_wdata;
          end
        end
        ADDR: begin
          if (rw == BUS_WRITE) begin
            state_q    <= WDATA;
            drive_data <= wdata_q;
          end else begin
            // Release the bus so the RAM can answer.
            state_q  <= RWAIT;
            drive    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        WDATA: begin
          state_q   <= IDLE;
          enable    <= 1'b0;
          rw        <= BUS_READ;
          drive     <= 1'b0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
        end
        RWAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            rsp_rdata <= bus;
            state_q   <= IDLE;
            enable    <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Single driver of the shared bus on the master side.
  tri_buf #(.WIDTH(WIDTH)) u_tri_buf (
    .rw   (drive),
    .data (drive_data),
    .bus  (bus)
  );

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two masters (READ_LATENCY 1 and 3), each on its own
// pulled-up bus with a small RAM model behind it.
module tb_ram_bus_master;
  import cuca1_bus_pkg::*;

  localparam int W    = 8;
  localparam int RL_A = 1;
  localparam int RL_B = 3;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic n_reset = 1'b0;
  int   cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- instance A (READ_LATENCY 1) ----------------
  logic         req_valid = 1'b0, req_rw = 1'b0;
  logic [W-1:0] req_addr = '0, req_wdata = '0;
  logic         req_ready, rsp_valid, enable, rw;
  logic [W-1:0] rsp_rdata;
  logic [1:0]   state;
  tri1  [W-1:0] bus;

  ram_bus_master #(.WIDTH(W), .READ_LATENCY(RL_A)) dut (
    .clock(clock), .n_reset(n_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .enable(enable), .rw(rw), .bus(bus), .state(state)
  );

  // ---------------- instance B (READ_LATENCY 3) ----------------
  logic         req_valid_b = 1'b0, req_rw_b = 1'b0;
  logic [W-1:0] req_addr_b = '0, req_wdata_b = '0;
  logic         req_ready_b, rsp_valid_b, enable_b, rw_b;
  logic [W-1:0] rsp_rdata_b;
  logic [1:0]   state_b;
  tri1  [W-1:0] bus_b;

  ram_bus_master #(.WIDTH(W), .READ_LATENCY(RL_B)) dut_b (
    .clock(clock), .n_reset(n_reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rw(req_rw_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .enable(enable_b), .rw(rw_b), .bus(bus_b), .state(state_b)
  );

  // ---------------- RAM models ----------------
  // Address latched on the first enabled cycle; later cycles write or drive.
  logic [W-1:0] mem_a [256];
  logic [W-1:0] mem_b [256];
  logic         seen_a, seen_b;
  logic [W-1:0] ra_a, ra_b;
  logic [1:0]   wc_a, wc_b;

  always @(posedge clock) begin
    if (!enable) begin
      seen_a <= 1'b0; wc_a <= 2'd0;
    end else if (!seen_a) begin
      seen_a <= 1'b1; ra_a <= bus; wc_a <= 2'd0;
    end else begin
      if (rw) mem_a[ra_a] <= bus;
      if (wc_a != 2'd3) wc_a <= wc_a + 2'd1;
    end
  end
  assign bus = (enable && !rw && seen_a) ? mem_a[ra_a] : 8'hzz;

  // The slow RAM only drives in the last wait cycle, so earlier ones show the pull-up.
  always @(posedge clock) begin
    if (!enable_b) begin
      seen_b <= 1'b0; wc_b <= 2'd0;
    end else if (!seen_b) begin
      seen_b <= 1'b1; ra_b <= bus_b; wc_b <= 2'd0;
    end else begin
      if (rw_b) mem_b[ra_b] <= bus_b;
      if (wc_b != 2'd3) wc_b <= wc_b + 2'd1;
    end
  end
  assign bus_b = (enable_b && !rw_b && seen_b && wc_b == 2'd2) ? mem_b[ra_b] : 8'hzz;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           exp_rd_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] mon_d;
  bit           mon_r;
  int           mon_c;
  bit           bus_x_seen = 1'b0;

  always @(negedge clock) begin
    if ($isunknown(bus) || $isunknown(bus_b)) bus_x_seen <= 1'b1;
    if (n_reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_d = exp_q.pop_front();
        mon_r = exp_rd_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("rsp_latency", cyc, mon_c);
        if (mon_r) check("rsp_rdata", 32'(rsp_rdata), 32'(mon_d));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] data,
                       input bit hold, input bit in_rsp_cycle);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (in_rsp_cycle) check("b2b_accept_in_rsp", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_rw = wr; req_addr = addr; req_wdata = data;
    exp_cyc_q.push_back(cyc + 1 + (wr ? 2 : 1 + RL_A));
    exp_rd_q.push_back(!wr);
    if (wr) begin
      ref_mem[addr] = data;
      exp_q.push_back(data);
    end else begin
      exp_q.push_back(ref_mem[addr]);
    end
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete(); exp_rd_q.delete(); exp_cyc_q.delete();
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int acc;
    int n;
    logic [W-1:0] ra, rd;

    // Reset state, sampled after the first edge with reset held.
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_bus_released", 32'(bus), 32'hFF);
    @(negedge clock);
    n_reset = 1'b1;

    // 1: write 0x0F to 0x0A
    issue(1'b1, 8'h0A, 8'h0F, 1'b0, 1'b0);
    @(negedge clock);
    check("t1_addr_bus", 32'(bus), 32'h0A);
    check("t1_addr_en", 32'(enable), 32'd1);
    check("t1_addr_rw", 32'(rw), 32'd1);
    check("t1_addr_state", 32'(state), 32'(ADDR));
    @(negedge clock);
    check("t1_wdata_bus", 32'(bus), 32'h0F);
    check("t1_wdata_state", 32'(state), 32'(WDATA));
    drain();
    check("t1_mem", 32'(mem_a[10]), 32'h0F);
    check("t1_idle_bus", 32'(bus), 32'hFF);
    check("t1_idle_en", 32'(enable), 32'd0);

    // 2: read back 0x0A
    issue(1'b0, 8'h0A, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    check("t2_addr_bus", 32'(bus), 32'h0A);
    check("t2_addr_rw", 32'(rw), 32'd0);
    @(negedge clock);
    check("t2_rwait_state", 32'(state), 32'(RWAIT));
    check("t2_rwait_en", 32'(enable), 32'd1);
    check("t2_rwait_bus_ram_only", 32'(bus), 32'h0F);
    drain();

    // 3: back-to-back with req_valid held high
    issue(1'b1, 8'h01, 8'h55, 1'b1, 1'b0);
    issue(1'b1, 8'h02, 8'hAA, 1'b1, 1'b1);
    issue(1'b0, 8'h01, 8'h00, 1'b1, 1'b1);
    issue(1'b0, 8'h02, 8'h00, 1'b0, 1'b1);
    drain();

    // 4: boundary addresses
    issue(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
    issue(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    issue(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    drain();
    check("t4_mem_00", 32'(mem_a[0]), 32'hFF);
    check("t4_mem_ff", 32'(mem_a[255]), 32'h00);
    check("t4_mem_01", 32'(mem_a[1]), 32'h55);

    // Random write/read pairs
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      issue(1'b1, ra, rd, 1'b0, 1'b0);
      issue(1'b0, ra, 8'h00, 1'b0, 1'b0);
    end
    drain();

    // 5: reset in the middle of WDATA
    issue(1'b1, 8'h0B, 8'h11, 1'b0, 1'b0);
    drain();
    issue(1'b1, 8'h0B, 8'h33, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("t5_pre_state", 32'(state), 32'(WDATA));
    #1 n_reset = 1'b0;
    #1;
    check("t5_rst_en", 32'(enable), 32'd0);
    check("t5_rst_bus", 32'(bus), 32'hFF);
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    check("t5_rst_state", 32'(state), 32'(IDLE));
    exp_q.delete(); exp_rd_q.delete(); exp_cyc_q.delete();
    ref_mem[8'h0B] = 8'h11;
    @(negedge clock);
    n_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("t5_mem_untouched", 32'(mem_a[11]), 32'h11);
    issue(1'b0, 8'h0A, 8'h00, 1'b0, 1'b0);
    drain();

    // 6: READ_LATENCY=3 instance, write then read 0x0A
    @(negedge clock);
    req_valid_b = 1'b1; req_rw_b = 1'b1; req_addr_b = 8'h0A; req_wdata_b = 8'h5A;
    acc = cyc + 1;
    @(posedge clock);
    #1 req_valid_b = 1'b0;
    n = 0;
    @(negedge clock);
    while (!rsp_valid_b && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t6_wr_latency", cyc, acc + 2);
    check("t6_mem", 32'(mem_b[10]), 32'h5A);
    @(negedge clock);
    req_valid_b = 1'b1; req_rw_b = 1'b0; req_addr_b = 8'h0A;
    acc = cyc + 1;
    @(posedge clock);
    #1 req_valid_b = 1'b0;
    @(negedge clock);
    check("t6_addr_bus", 32'(bus_b), 32'h0A);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("t6_rwait_state", 32'(state_b), 32'(RWAIT));
      check("t6_rwait_rsp", 32'(rsp_valid_b), 32'd0);
      check("t6_rwait_bus", 32'(bus_b), (k < 3) ? 32'hFF : 32'h5A);
    end
    @(negedge clock);
    check("t6_rsp_valid", 32'(rsp_valid_b), 32'd1);
    check("t6_rsp_cycle", cyc, acc + 4);
    check("t6_rsp_rdata", 32'(rsp_rdata_b), 32'h5A);
    check("t6_idle_en", 32'(enable_b), 32'd0);

    check("bus_contention", 32'(bus_x_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the run must always end by itself.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
